// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer; start bit goes out one clock after acceptance.
// Each bit is held BAUD_END clocks; tx_rdy is low while the holding buffer is full (byte ignored, not lost).
module uart_tx #(
  parameter int BAUD_END = 434
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_vld,
  output logic       tx_rdy,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rs232_tx
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [8:0] BIT_LAST = 9'(BAUD_END - 1);
  localparam logic [8:0] DONE_AT  = 9'(BAUD_END - 2);

  state_e     state_q;
  logic [8:0] baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       tx_rdy_q;
  logic       tx_busy_q;
  logic       tx_done_q;
  logic       tx_q;

  logic       bit_end;
  logic       load;
  logic       accept;

  always_comb begin
    bit_end    = (baud_cnt_q == BIT_LAST);
    // The shifter takes the buffered byte when idle, or at the end of a stop bit for a zero-gap frame.
    load       = buf_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    accept     = tx_data_vld && tx_rdy_q;

    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (load) begin
      buf_full_d = 1'b0;
    end else if (accept) begin
      buf_full_d = 1'b1;
      buf_d      = tx_data;
    end

    baud_cnt_d = '0;
    if ((state_q != IDLE) && !bit_end) begin
      baud_cnt_d = baud_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_rdy_q   <= 1'b1;
      baud_cnt_q <= '0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_rdy_q   <= ~buf_full_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      // Registered one clock early so the pulse lines up with the last clock of the stop bit.
      tx_done_q <= (state_q == STOP) && (baud_cnt_q == DONE_AT);
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q   <= buf_q;
            state_q   <= START;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (load) begin
              shift_q <= buf_q;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q   <= IDLE;
              tx_busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          tx_q      <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_rdy   = tx_rdy_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign rs232_tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a full-rate instance for timing/boundary cases and a fast instance for 256-byte loopback.
module tb_uart_tx;
  localparam int B  = 434;
  localparam int FR = 10 * B;
  localparam int B2 = 16;
  localparam int FR2 = 10 * B2;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic       s_rst_n, rst2_n;
  logic [7:0] tx_data, lb_data;
  logic       tx_data_vld, lb_vld;
  logic       tx_rdy, tx_busy, tx_done, rs232_tx;
  logic       lb_rdy, lb_busy, lb_done, lb_tx;

  uart_tx #(.BAUD_END(B)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .tx_data(tx_data), .tx_data_vld(tx_data_vld),
    .tx_rdy(tx_rdy), .tx_busy(tx_busy), .tx_done(tx_done), .rs232_tx(rs232_tx)
  );

  uart_tx #(.BAUD_END(B2)) u_lb (
    .sclk(sclk), .s_rst_n(rst2_n), .tx_data(lb_data), .tx_data_vld(lb_vld),
    .tx_rdy(lb_rdy), .tx_busy(lb_busy), .tx_done(lb_done), .rs232_tx(lb_tx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- full-rate monitor / scoreboard ----------------
  logic [7:0] sb[$];
  int frames = 0, last_start = -1, last_gap = -1, prev_end = -1, acc_cyc = 0, done_cnt = 0;
  bit mon_active = 1'b0;

  always @(negedge sclk) if (tx_done === 1'b1) done_cnt++;

  task automatic mon_frame();
    logic [7:0] exp, got;
    logic [9:0] fb;
    int bad = 0, bbad = 0, dbad = 0, start;
    mon_active = 1'b1;
    start = cyc;
    if (prev_end >= 0) last_gap = start - prev_end - 1;
    last_start = start;
    if (sb.size() == 0) begin
      check("unexpected_frame", 1, 0);
      exp = 8'h00;
    end else begin
      exp = sb.pop_front();
    end
    fb  = {1'b1, exp, 1'b0};
    got = 8'h00;
    for (int n = 0; n < FR; n++) begin
      if (n > 0) @(negedge sclk);
      if (s_rst_n !== 1'b1) begin
        mon_active = 1'b0;
        prev_end   = -1;
        return;
      end
      if (rs232_tx !== fb[n / B]) bad++;
      if (tx_busy !== 1'b1) bbad++;
      if (tx_done !== (n == FR - 1)) dbad++;
      if ((n % B == B / 2) && (n / B >= 1) && (n / B <= 8)) got[n / B - 1] = rs232_tx;
    end
    check("frame_bit_samples_bad", bad, 0);
    check("frame_busy_samples_bad", bbad, 0);
    check("frame_done_samples_bad", dbad, 0);
    check("frame_data", got, exp);
    prev_end   = cyc;
    frames++;
    mon_active = 1'b0;
  endtask

  initial forever begin
    @(negedge sclk);
    if (s_rst_n === 1'b1 && rs232_tx === 1'b0) mon_frame();
  end

  // ---------------- loopback receiver model ----------------
  logic [7:0] lq[$];
  int rx_cnt = 0, first_fall = -1, last_done2 = -1, done2_cnt = 0;

  always @(negedge sclk) if (lb_done === 1'b1) begin
    done2_cnt++;
    last_done2 = cyc;
  end

  task automatic lb_frame();
    logic [9:0] s;
    logic [7:0] exp;
    if (first_fall < 0) first_fall = cyc;
    s = '0;
    for (int n = 0; n < FR2; n++) begin
      if (n > 0) @(negedge sclk);
      if (n % B2 == B2 / 2) s[n / B2] = lb_tx;
    end
    check("lb_start_stop", {s[9], s[0]}, 2'b10);
    exp = (lq.size() != 0) ? lq.pop_front() : 8'hxx;
    check("lb_data", s[8:1], exp);
    rx_cnt++;
  endtask

  initial forever begin
    @(negedge sclk);
    if (rst2_n === 1'b1 && lb_tx === 1'b0) lb_frame();
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    int w = 0;
    @(negedge sclk);
    tx_data     = b;
    tx_data_vld = 1'b1;
    while (tx_rdy !== 1'b1 && w < 3 * FR) begin
      @(negedge sclk);
      w++;
    end
    if (w >= 3 * FR) begin
      check("send_timeout", 0, 1);
    end else begin
      sb.push_back(b);
      acc_cyc = cyc + 1;
    end
    @(posedge sclk);
  endtask

  task automatic lsend(input logic [7:0] b);
    int w = 0;
    @(negedge sclk);
    lb_data = b;
    lb_vld  = 1'b1;
    while (lb_rdy !== 1'b1 && w < 3 * FR2) begin
      @(negedge sclk);
      w++;
    end
    if (w >= 3 * FR2) check("lb_send_timeout", 0, 1);
    else lq.push_back(b);
    @(posedge sclk);
  endtask

  task automatic drop_vld();
    @(negedge sclk);
    tx_data_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while ((tx_busy !== 1'b0 || sb.size() != 0 || mon_active) && w < budget) begin
      @(negedge sclk);
      w++;
    end
    check("drain_timeout", w < budget, 1);
  endtask

  task automatic main_seq();
    int lows, f0, d0, acc, w;
    // idle line with no stimulus
    lows = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge sclk);
      if (rs232_tx !== 1'b1 || tx_rdy !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("idle_5000_bad", lows, 0);

    // single byte, exact latency and tx_done position
    d0 = done_cnt;
    send(8'h55);
    acc = acc_cyc;
    drop_vld();
    w = 0;
    while (tx_done !== 1'b1 && w < FR + 20) begin
      @(negedge sclk);
      w++;
    end
    check("done_cycle_after_accept", cyc - acc, FR);
    check("start_latency", last_start - acc, 1);
    @(negedge sclk);
    check("busy_after_done", tx_busy, 0);
    check("line_after_done", rs232_tx, 1);
    wait_idle(100);
    check("single_done_pulses", done_cnt - d0, 1);

    // back-to-back with vld held high
    d0 = done_cnt;
    f0 = frames;
    send(8'hA5);
    send(8'h3C);
    @(negedge sclk);
    check("rdy_low_while_buffered", tx_rdy, 0);
    check("busy_while_buffered", tx_busy, 1);
    tx_data_vld = 1'b0;
    tx_data     = 8'h00;
    wait_idle(3 * FR);
    check("b2b_frames", frames - f0, 2);
    check("b2b_gap", last_gap, 0);
    check("b2b_done_pulses", done_cnt - d0, 2);

    // vld while buffer full is ignored
    f0 = frames;
    send(8'h11);
    send(8'h22);
    @(negedge sclk);
    check("rdy_low_before_ignored", tx_rdy, 0);
    tx_data = 8'hFF;
    @(negedge sclk);
    tx_data_vld = 1'b0;
    tx_data     = 8'h00;
    wait_idle(3 * FR);
    check("ignored_frames", frames - f0, 2);

    // reset during data bit 3 with a second byte buffered
    send(8'h81);
    send(8'h42);
    drop_vld();
    repeat (4 * B + 100) @(negedge sclk);
    check("pre_reset_line", rs232_tx, 0);
    check("pre_reset_buffered", tx_rdy, 0);
    #2 s_rst_n = 1'b0;
    #1;
    check("mid_reset_line", rs232_tx, 1);
    check("mid_reset_rdy", tx_rdy, 1);
    check("mid_reset_busy", tx_busy, 0);
    sb.delete();
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
    f0   = frames;
    lows = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk);
      if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("post_reset_quiet_bad", lows, 0);
    check("post_reset_frames", frames - f0, 0);
  endtask

  task automatic loop_seq();
    int w = 0;
    for (int i = 0; i < 256; i++) lsend(8'(i));
    @(negedge sclk);
    lb_vld = 1'b0;
    while ((lb_busy !== 1'b0 || lq.size() != 0) && w < 4 * FR2) begin
      @(negedge sclk);
      w++;
    end
    check("lb_drain_timeout", w < 4 * FR2, 1);
    repeat (2 * B2) @(negedge sclk);
    check("lb_rx_count", rx_cnt, 256);
    check("lb_done_count", done2_cnt, 256);
    check("lb_continuous_span", last_done2 - first_fall, 256 * FR2 - 1);
  endtask

  initial begin
    s_rst_n     = 1'b1;
    rst2_n      = 1'b1;
    tx_data     = 8'h00;
    tx_data_vld = 1'b0;
    lb_data     = 8'h00;
    lb_vld      = 1'b0;
    #2;
    s_rst_n = 1'b0;
    rst2_n  = 1'b0;
    #1;
    check("reset_line", rs232_tx, 1);
    check("reset_rdy", tx_rdy, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
    rst2_n  = 1'b1;
    fork
      main_seq();
      loop_seq();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
